// File: rtl/stream_demux_pkg.sv
// Shared defaults and elaboration-time helpers for the stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_N_OUT  = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N_OUT valid/ready demux with a one-entry holding stage, broadcast
// delivery and out-of-range select dropping.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_OUT  = DEF_N_OUT,
  parameter int unsigned SEL_W  = clog2(N_OUT),
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_drop,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam logic [SEL_W:0] N_OUT_X = (SEL_W+1)'(N_OUT);

  logic              hold_valid, hold_valid_d;
  logic [DATA_W-1:0] hold_data;
  logic [SEL_W-1:0]  hold_sel;
  logic              hold_bcast;
  logic [N_OUT-1:0]  done, done_d;
  logic [N_OUT-1:0]  uni_mask;
  logic              rel, acc, oor, load;

  // Outputs depend only on the holding registers and out_ready.
  always_comb begin
    uni_mask = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      uni_mask[k] = (hold_sel == SEL_W'(k));
    end

    out_valid = '0;
    if (hold_valid) out_valid = hold_bcast ? ~done : uni_mask;

    out_data = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (out_valid[k]) out_data[k*DATA_W +: DATA_W] = hold_data;
    end

    rel  = hold_valid & (hold_bcast ? &(done | out_ready) : |(uni_mask & out_ready));
    in_ready = !hold_valid | rel;
    acc  = in_valid & in_ready;
    oor  = acc & !in_bcast & ({1'b0, in_sel} >= N_OUT_X);
    load = acc & !oor;

    hold_valid_d = load | (hold_valid & !rel);

    // A load without release only happens while EMPTY, where done is already clear.
    done_d = done;
    if (rel) begin
      done_d = '0;
    end else if (hold_valid && hold_bcast) begin
      done_d = done | (out_valid & out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_sel   <= '0;
      hold_bcast <= 1'b0;
      done       <= '0;
      err_drop   <= 1'b0;
    end else begin
      hold_valid <= hold_valid_d;
      done       <= done_d;
      err_drop   <= oor;
      if (load) begin
        hold_data  <= in_data;
        hold_sel   <= in_sel;
        hold_bcast <= in_bcast;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (oor),
    .count(drop_cnt)
  );

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised 1-to-N_OUT demultiplexer for valid/ready streams; next generation of the team's combinational 1:4 demux.
- Adds a one-entry registered holding stage, per-output backpressure, a broadcast mode and out-of-range select handling with a drop counter.
- Sits between a single producer and N_OUT consumers, such as channel engines fed from one command stream.

Parameters:
- DATA_W, 8, payload width in bits.
- N_OUT, 4, number of output channels (2..16; need not be a power of two).
- SEL_W, $clog2(N_OUT), select width (derived; do not override).
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel for unicast.
- in_bcast  input  1  1 = deliver the beat to all N_OUT channels; in_sel is ignored.
- out_valid  output  N_OUT  per-channel valid.
- out_ready  input  N_OUT  per-channel ready.
- out_data  output  N_OUT*DATA_W  lane k = bits [k*DATA_W +: DATA_W].
- err_drop  output  1  one-cycle pulse: an out-of-range beat was dropped.
- drop_cnt  output  CNT_W  count of dropped beats, saturating.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: hold_valid=0, done=0, out_valid=0, out_data=0, err_drop=0, drop_cnt=0, in_ready=1.
- Internal state is hold_valid, hold_data, hold_sel, hold_bcast, and done[N_OUT].
- State machine, derived from the internal state:
  - EMPTY: hold_valid=0.
  - UNI: hold_valid=1, hold_bcast=0.
  - BCAST: hold_valid=1, hold_bcast=1.
- Acceptance: acc = in_valid & in_ready.
- in_ready = !hold_valid | release. It is combinational and permits full throughput of one beat per cycle.
- out_valid and out_data are driven from registers only; there is no combinational in-to-out path.
- UNI:
  - out_valid[k] = (k==hold_sel).
  - release = out_ready[hold_sel].
- BCAST:
  - out_valid[k] = !done[k].
  - Set done[k] on out_valid[k] & out_ready[k].
  - release = AND over k of (done[k] | out_ready[k]), so consumers may accept on different cycles.
  - done is cleared on release.
- out_data lane k = hold_data when out_valid[k], else 0.
- Latency: an accepted beat appears on out_valid in the next cycle.
- On acc & release in the same cycle, the holding register reloads with the new beat; no bubble is inserted.
- Out-of-range select (acc & !in_bcast & in_sel>=N_OUT):
  - The beat is consumed and not loaded; the holding register is unaffected.
  - err_drop=1 in the next cycle only.
  - drop_cnt increments and saturates at 2^CNT_W-1.
  - While EMPTY, such beats drain one per cycle.
- out_ready is ignored on channels where out_valid=0.
- Producer rule: in_data, in_sel and in_bcast must be stable while in_valid=1 & in_ready=0.
- Mid-operation reset asserts immediately: the holding register is discarded, done clears, and the counter clears. After deassertion the block is EMPTY.
- For N_OUT a power of two, the drop path is unreachable; err_drop stays 0.

Decomposition:
- Package stream_demux_pkg holds the default widths and a localparam function for clog2.
- The state is derived from hold_valid/hold_bcast, so no enum is needed.
- One natural sub-module is sat_counter (CNT_W, inc, count), which implements drop_cnt. All other logic stays in one module.

Test Plan:
- Unicast sweep (N_OUT=4, all out_ready=1): sel 0,1,2,3 with data 0xA0..0xA3 on consecutive cycles → out_valid 0001,0010,0100,1000 on cycles 1-4; lane k carries 0xA0+k; in_ready stays 1.
- Backpressure: sel=2, data 0x5C, out_ready[2]=0 for 3 cycles → out_valid=0100 held; in_ready=0 with a second beat pending; the second beat appears the cycle after out_ready[2]=1.
- Broadcast staggered: in_bcast=1, data 0x77; out_ready 0001, then 0110, then 1000 → out_valid 1111, 1110, 1000, then release; in_ready=1 on the cycle with out_ready 1000.
- Out-of-range (N_OUT=5, sel=7, data 0x33) → no out_valid; err_drop pulses 1 cycle; drop_cnt=1; 300 such beats with CNT_W=8 → drop_cnt=255.
- Reset mid-broadcast: assert rst_n=0 after one channel has accepted → all outputs 0 asynchronously; after release, a unicast sel=1 delivers normally with done clear.
- Back-to-back mixed traffic: random sel/bcast/ready for 10k cycles against a scoreboard → every in-range beat is delivered exactly once per target, in order; drop count matches.
